// File: rtl/uart_cpu_pkg.sv
// -----------------------------------------------------------------------------
// uart_cpu_pkg
// Shared definitions for the UART <-> CPU sequencer:
//   - seq_state_t      : sequencer FSM state encoding
//   - ORDER_*          : byte-order selectors for the MSB_FIRST parameter
//   - DEFAULT_TIMEOUT  : default watchdog limit in cycles
//   - pack_word        : builds a 16-bit word from two bytes in wire order
//   - wire_byte        : selects the first/second wire byte of a 16-bit word
// Optional feature macro used by the sequencer: SEQ_TIMEOUT_EN
// -----------------------------------------------------------------------------
package uart_cpu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRx2,
      StStart,
      StWaitCpu,
      StTx1,
      StTx1w,
      StTx2,
      StTx2w
   } seq_state_t;

   localparam bit ORDER_MSB_FIRST = 1'b1;
   localparam bit ORDER_LSB_FIRST = 1'b0;

   localparam int unsigned DEFAULT_TIMEOUT = 1000;

   // First wire byte lands in [15:8] for MSB-first, in [7:0] otherwise.
   function automatic logic [15:0] pack_word(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input bit         order);
      if (order == ORDER_MSB_FIRST) begin
         return {first, second};
      end
      return {second, first};
   endfunction

   // idx 0 = first byte on the wire, idx 1 = second byte.
   function automatic logic [7:0] wire_byte(input logic [15:0] word,
                                            input bit          order,
                                            input bit          idx);
      if ((order == ORDER_LSB_FIRST) ^ idx) begin
         return word[7:0];
      end
      return word[15:8];
   endfunction

endpackage

// File: rtl/uart_cpu_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// 16-bit cycle counter with synchronous clear and count enable. o_expire is
// asserted in the enabled cycle whose count step would reach LIMIT, so the
// owner sees expiry exactly LIMIT enabled cycles after the last clear.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_clear   : zero the counter (priority over enable)
//   i_enable  : count this cycle
//   o_expire  : combinational expiry flag
// -----------------------------------------------------------------------------
module seq_watchdog #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

   logic [15:0] r_count;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= 16'd0;
      end else if (i_clear) begin
         r_count <= 16'd0;
      end else if (i_enable) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_expire = i_enable && (r_count == LIMIT_M1);

endmodule

// File: rtl/uart_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cpu_sequencer
// One-transaction-at-a-time sequencer between UART RX/TX and a 16-bit CPU:
// two RX bytes -> operand, one-cycle cpu_start, wait cpu_done, result sent
// back as two TX bytes. All outputs are registered and reset to 0.
// Optional macro SEQ_TIMEOUT_EN adds a WAIT_CPU watchdog (seq_watchdog).
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_rx_done/i_rx_data        : received byte strobe and data
//   i_cpu_done/i_cpu_result    : CPU completion strobe and result word
//   i_tx_done                  : transmitter finished current byte
//   o_cpu_start/o_cpu_operand  : CPU start pulse and operand word
//   o_tx_en/o_tx_data          : transmit request pulse and byte
//   o_busy                     : state is not IDLE
//   o_rx_overrun               : pulse when an rx byte is dropped
//   o_timeout_err              : pulse on watchdog abort (0 without macro)
// -----------------------------------------------------------------------------
module uart_cpu_sequencer
   import uart_cpu_pkg::*;
#(
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rx_done,
   input  logic [7:0]  i_rx_data,
   input  logic        i_cpu_done,
   input  logic [15:0] i_cpu_result,
   input  logic        i_tx_done,
   output logic        o_cpu_start,
   output logic [15:0] o_cpu_operand,
   output logic        o_tx_en,
   output logic [7:0]  o_tx_data,
   output logic        o_busy,
   output logic        o_rx_overrun,
   output logic        o_timeout_err
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   seq_state_t  r_state;
   seq_state_t  w_state_next;
   logic [7:0]  r_first_byte, w_first_byte;
   logic [15:0] r_result, w_result;
   logic [15:0] r_cpu_operand, w_cpu_operand;
   logic [7:0]  r_tx_data, w_tx_data;
   logic        r_cpu_start, w_cpu_start;
   logic        r_tx_en, w_tx_en;
   logic        r_busy, w_busy;
   logic        r_rx_overrun, w_rx_overrun;
   logic        w_in_wait;
   logic        w_expire;

   assign w_in_wait = (r_state == StWaitCpu);

`ifdef SEQ_TIMEOUT_EN
   logic r_timeout_err;
   logic w_timeout_err;

   // Counter is held at zero outside WAIT_CPU, so it restarts on every entry.
   seq_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (!w_in_wait),
      .i_enable (w_in_wait),
      .o_expire (w_expire)
   );

   // cpu_done wins a same-cycle tie with expiry.
   assign w_timeout_err = w_expire && !i_cpu_done;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout_err;
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign w_expire      = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   always_comb begin
      w_state_next  = r_state;
      w_first_byte  = r_first_byte;
      w_result      = r_result;
      w_cpu_operand = r_cpu_operand;
      w_tx_data     = r_tx_data;
      // Only IDLE and RX2 consume bytes; anywhere else the byte is dropped.
      w_rx_overrun  = i_rx_done && (r_state != StIdle) && (r_state != StRx2);

      unique case (r_state)
         StIdle: begin
            if (i_rx_done) begin
               w_first_byte = i_rx_data;
               w_state_next = StRx2;
            end
         end
         StRx2: begin
            if (i_rx_done) begin
               w_cpu_operand = pack_word(r_first_byte, i_rx_data, MSB_FIRST);
               w_state_next  = StStart;
            end
         end
         StStart: begin
            w_state_next = StWaitCpu;
         end
         StWaitCpu: begin
            if (i_cpu_done) begin
               w_result     = i_cpu_result;
               // First byte is loaded from the live result so tx_en can rise next cycle.
               w_tx_data    = wire_byte(i_cpu_result, MSB_FIRST, 1'b0);
               w_state_next = StTx1;
            end else if (w_expire) begin
               w_state_next = StIdle;
            end
         end
         StTx1: begin
            w_state_next = StTx1w;
         end
         StTx1w: begin
            if (i_tx_done) begin
               w_tx_data    = wire_byte(r_result, MSB_FIRST, 1'b1);
               w_state_next = StTx2;
            end
         end
         StTx2: begin
            w_state_next = StTx2w;
         end
         StTx2w: begin
            if (i_tx_done) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase

      // Registered outputs follow the state being entered.
      w_cpu_start = (w_state_next == StStart);
      w_tx_en     = (w_state_next == StTx1) || (w_state_next == StTx2);
      w_busy      = (w_state_next != StIdle);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= StIdle;
         r_first_byte  <= 8'd0;
         r_result      <= 16'd0;
         r_cpu_operand <= 16'd0;
         r_tx_data     <= 8'd0;
         r_cpu_start   <= 1'b0;
         r_tx_en       <= 1'b0;
         r_busy        <= 1'b0;
         r_rx_overrun  <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_first_byte  <= w_first_byte;
         r_result      <= w_result;
         r_cpu_operand <= w_cpu_operand;
         r_tx_data     <= w_tx_data;
         r_cpu_start   <= w_cpu_start;
         r_tx_en       <= w_tx_en;
         r_busy        <= w_busy;
         r_rx_overrun  <= w_rx_overrun;
      end
   end

   assign o_cpu_start   = r_cpu_start;
   assign o_cpu_operand = r_cpu_operand;
   assign o_tx_en       = r_tx_en;
   assign o_tx_data     = r_tx_data;
   assign o_busy        = r_busy;
   assign o_rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_uart_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_cpu_sequencer
// Drives one MSB-first and one LSB-first sequencer with identical stimulus.
// Expected operands and TX bytes are queued when stimulus is applied and
// popped by a monitor whenever a DUT raises cpu_start / tx_en.
// -----------------------------------------------------------------------------
module tb_uart_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        cpu_done;
   logic [15:0] cpu_result;
   logic        tx_done;

   logic        m_cpu_start, m_tx_en, m_busy, m_rx_overrun, m_timeout_err;
   logic [15:0] m_cpu_operand;
   logic [7:0]  m_tx_data;
   logic        l_cpu_start, l_tx_en, l_busy, l_rx_overrun, l_timeout_err;
   logic [15:0] l_cpu_operand;
   logic [7:0]  l_tx_data;

   always #5 clk = ~clk;

   uart_cpu_sequencer #(
      .MSB_FIRST      (1'b1),
      .TIMEOUT_CYCLES (10)
   ) u_dut_msb (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_rx_done     (rx_done),
      .i_rx_data     (rx_data),
      .i_cpu_done    (cpu_done),
      .i_cpu_result  (cpu_result),
      .i_tx_done     (tx_done),
      .o_cpu_start   (m_cpu_start),
      .o_cpu_operand (m_cpu_operand),
      .o_tx_en       (m_tx_en),
      .o_tx_data     (m_tx_data),
      .o_busy        (m_busy),
      .o_rx_overrun  (m_rx_overrun),
      .o_timeout_err (m_timeout_err)
   );

   uart_cpu_sequencer #(
      .MSB_FIRST      (1'b0),
      .TIMEOUT_CYCLES (10)
   ) u_dut_lsb (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_rx_done     (rx_done),
      .i_rx_data     (rx_data),
      .i_cpu_done    (cpu_done),
      .i_cpu_result  (cpu_result),
      .i_tx_done     (tx_done),
      .o_cpu_start   (l_cpu_start),
      .o_cpu_operand (l_cpu_operand),
      .o_tx_en       (l_tx_en),
      .o_tx_data     (l_tx_data),
      .o_busy        (l_busy),
      .o_rx_overrun  (l_rx_overrun),
      .o_timeout_err (l_timeout_err)
   );

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] res;
      logic [15:0] op_m;
      logic [15:0] op_l;
      bit          overrun;
      int          wait_n;
   } vec_t;

   vec_t vecs[5];

   int n_chk  = 0;
   int n_fail = 0;
   int ovr_m  = 0;
   int ovr_l  = 0;
   int tmo_m  = 0;
   int tmo_l  = 0;

   logic [15:0] q_op_m[$];
   logic [15:0] q_op_l[$];
   logic [7:0]  q_tx_m[$];
   logic [7:0]  q_tx_l[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_unexpected(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: output pulse with nothing expected at %0t", name, $time);
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (m_cpu_start) begin
         if (q_op_m.size() == 0) fail_unexpected("cpu_start_msb");
         else chk("operand_msb", m_cpu_operand, q_op_m.pop_front());
      end
      if (l_cpu_start) begin
         if (q_op_l.size() == 0) fail_unexpected("cpu_start_lsb");
         else chk("operand_lsb", l_cpu_operand, q_op_l.pop_front());
      end
      if (m_tx_en) begin
         if (q_tx_m.size() == 0) fail_unexpected("tx_en_msb");
         else chk("tx_data_msb", m_tx_data, q_tx_m.pop_front());
      end
      if (l_tx_en) begin
         if (q_tx_l.size() == 0) fail_unexpected("tx_en_lsb");
         else chk("tx_data_lsb", l_tx_data, q_tx_l.pop_front());
      end
      if (m_rx_overrun) ovr_m++;
      if (l_rx_overrun) ovr_l++;
      if (m_timeout_err) tmo_m++;
      if (l_timeout_err) tmo_l++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic pulse_cpu(input logic [15:0] r);
      cpu_result = r;
      cpu_done   = 1'b1;
      tick();
      cpu_done   = 1'b0;
   endtask

   task automatic pulse_tx();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic push_result(input logic [15:0] r);
      logic [15:0] w;
      w = r;
      q_tx_m.push_back(w[15:8]);
      q_tx_m.push_back(w[7:0]);
      q_tx_l.push_back(w[7:0]);
      q_tx_l.push_back(w[15:8]);
   endtask

   // Receive two bytes; returns in the first WAIT_CPU cycle.
   task automatic rx_pair(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [15:0] op_m, input logic [15:0] op_l);
      q_op_m.push_back(op_m);
      q_op_l.push_back(op_l);
      pulse_rx(b0);
      chk("busy_after_rx1", {l_busy, m_busy}, 2'b11);
      pulse_rx(b1);
      chk("cpu_start_latency", {l_cpu_start, m_cpu_start}, 2'b11);
      tick();
      chk("cpu_start_one_cycle", {l_cpu_start, m_cpu_start}, 2'b00);
   endtask

   // From WAIT_CPU: complete cpu and both TX bytes.
   task automatic finish_txn(input logic [15:0] res);
      push_result(res);
      pulse_cpu(res);
      chk("tx_en1_latency", {l_tx_en, m_tx_en}, 2'b11);
      tick();
      pulse_tx();
      chk("tx_en2_latency", {l_tx_en, m_tx_en}, 2'b11);
      tick();
      pulse_tx();
      chk("busy_low_after_tx2", {l_busy, m_busy}, 2'b00);
      chk("tx_queue_drained", q_tx_m.size() + q_tx_l.size(), 0);
   endtask

   task automatic do_txn(input vec_t v);
      int ovr0;
      rx_pair(v.b0, v.b1, v.op_m, v.op_l);
      if (v.overrun) begin
         ovr0 = ovr_m + ovr_l;
         pulse_rx(8'h55);
         tick();
         chk("overrun_pulse_count", ovr_m + ovr_l - ovr0, 2);
         chk("operand_held_msb", m_cpu_operand, v.op_m);
         chk("operand_held_lsb", l_cpu_operand, v.op_l);
      end
      repeat (v.wait_n) tick();
      finish_txn(v.res);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      bit  found;
      vec_t v;

      vecs[0] = '{8'h12, 8'h34, 16'hABCD, 16'h1234, 16'h3412, 1'b0, 0};
      vecs[1] = '{8'hFF, 8'h00, 16'h0001, 16'hFF00, 16'h00FF, 1'b0, 3};
      vecs[2] = '{8'hA5, 8'h5A, 16'h8000, 16'hA55A, 16'h5AA5, 1'b1, 0};
      vecs[3] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
      vecs[4] = '{8'h80, 8'h01, 16'hFFFE, 16'h8001, 16'h0180, 1'b0, 5};

      rst_n      = 1'b0;
      rx_done    = 1'b0;
      rx_data    = 8'h00;
      cpu_done   = 1'b0;
      cpu_result = 16'h0000;
      tx_done    = 1'b0;
      tick();
      tick();
      chk("reset_msb", {m_cpu_start, m_cpu_operand, m_tx_en, m_tx_data, m_busy, m_rx_overrun,
                        m_timeout_err}, 0);
      chk("reset_lsb", {l_cpu_start, l_cpu_operand, l_tx_en, l_tx_data, l_busy, l_rx_overrun,
                        l_timeout_err}, 0);
      rst_n = 1'b1;
      tick();

      // Back-to-back table transactions: each first rx lands on the cycle busy drops.
      for (int i = 0; i < 5; i++) begin
         do_txn(vecs[i]);
      end
      tick();

      // Reset while waiting for the first tx_done.
      rx_pair(8'h12, 8'h34, 16'h1234, 16'h3412);
      push_result(16'hBEEF);
      pulse_cpu(16'hBEEF);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midreset_msb", {m_cpu_start, m_cpu_operand, m_tx_en, m_tx_data, m_busy, m_rx_overrun,
                           m_timeout_err}, 0);
      chk("midreset_lsb", {l_cpu_start, l_cpu_operand, l_tx_en, l_tx_data, l_busy, l_rx_overrun,
                           l_timeout_err}, 0);
      q_tx_m.delete();
      q_tx_l.delete();
      tick();
      rst_n = 1'b1;
      tick();
      v = '{8'h00, 8'h01, 16'h5A5A, 16'h0001, 16'h0100, 1'b0, 0};
      do_txn(v);
      tick();

`ifdef SEQ_TIMEOUT_EN
      // No cpu_done: abort 10 cycles after WAIT_CPU entry.
      rx_pair(8'h11, 8'h22, 16'h1122, 16'h2211);
      n     = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         n++;
         if (m_timeout_err) found = 1'b1;
      end
      chk("timeout_seen", found, 1);
      chk("timeout_latency", n, 10);
      chk("timeout_both", {l_timeout_err, m_timeout_err}, 2'b11);
      chk("timeout_idle", {l_busy, m_busy, l_tx_en, m_tx_en}, 0);
      tick();
      chk("timeout_one_cycle", {l_timeout_err, m_timeout_err}, 2'b00);

      // cpu_done on the expiry edge wins.
      rx_pair(8'h33, 8'h44, 16'h3344, 16'h4433);
      repeat (9) tick();
      finish_txn(16'hC0DE);
      tick();
      chk("timeout_count_msb", tmo_m, 1);
      chk("timeout_count_lsb", tmo_l, 1);
`else
      // No watchdog: a long CPU wait must still complete normally.
      v = '{8'h77, 8'h88, 16'h1357, 16'h7788, 16'h8877, 1'b0, 40};
      do_txn(v);
      tick();
      chk("timeout_count_msb", tmo_m, 0);
      chk("timeout_count_lsb", tmo_l, 0);
`endif

      chk("overrun_total", ovr_m + ovr_l, 2);
      chk("op_queue_drained", q_op_m.size() + q_op_l.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
